// File: rtl/seq_mult_pkg.sv
// Shared types and limits for the sequential shift-add multiplier.
package seq_mult_pkg;

  localparam int unsigned SEQ_MULT_MAX_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } seq_mult_state_t;

endpackage

// File: rtl/seq_mult_if.sv
// Start/busy/done handshake and operand/product bus of the multiplier core.
// The sgn mode select exists only when SEQ_MULT_SIGNED_EN is defined.
interface seq_mult_if #(
  parameter int unsigned WIDTH = 8
);
  logic                 clr;
  logic                 start;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
`ifdef SEQ_MULT_SIGNED_EN
  logic                 sgn;
`endif
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

`ifdef SEQ_MULT_SIGNED_EN
  modport master (output clr, start, multiplicand, multiplier, sgn,
                  input  busy, done, product);
  modport slave  (input  clr, start, multiplicand, multiplier, sgn,
                  output busy, done, product);
`else
  modport master (output clr, start, multiplicand, multiplier,
                  input  busy, done, product);
  modport slave  (input  clr, start, multiplicand, multiplier,
                  output busy, done, product);
`endif
endinterface

// File: rtl/seq_mult_dp.sv
// Multiplier datapath: M, ACC and Q registers with the add/subtract/shift step.
// Signed support (sign-extended M, arithmetic shift, final-step subtract) needs SEQ_MULT_SIGNED_EN.
module seq_mult_dp #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               load,
  input  logic               step,
`ifdef SEQ_MULT_SIGNED_EN
  input  logic               last,
  input  logic               sgn,
`endif
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic [2*WIDTH-1:0] result
);
  logic [WIDTH:0]   m_q;
  logic [WIDTH:0]   acc_q;
  logic [WIDTH:0]   acc_nxt;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH:0]   m_ext;
  logic             fill;
`ifdef SEQ_MULT_SIGNED_EN
  logic             sgn_q;
`endif

  always_comb begin
    sum = acc_q;
`ifdef SEQ_MULT_SIGNED_EN
    m_ext = {multiplicand[WIDTH-1] & sgn, multiplicand};
    if (q_q[0]) sum = (sgn_q && last) ? acc_q - m_q : acc_q + m_q;
    fill = sgn_q & sum[WIDTH];
`else
    m_ext = {1'b0, multiplicand};
    if (q_q[0]) sum = acc_q + m_q;
    fill = 1'b0;
`endif
    // {ACC, Q} shifts right as one register; ACC's LSB enters Q's MSB.
    acc_nxt = {fill, sum[WIDTH:1]};
    q_nxt   = {sum[0], q_q[WIDTH-1:1]};
    result  = {acc_nxt[WIDTH-1:0], q_nxt};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q   <= '0;
      acc_q <= '0;
      q_q   <= '0;
`ifdef SEQ_MULT_SIGNED_EN
      sgn_q <= 1'b0;
`endif
    end else if (clr) begin
      m_q   <= '0;
      acc_q <= '0;
      q_q   <= '0;
`ifdef SEQ_MULT_SIGNED_EN
      sgn_q <= 1'b0;
`endif
    end else if (load) begin
      m_q   <= m_ext;
      acc_q <= '0;
      q_q   <= multiplier;
`ifdef SEQ_MULT_SIGNED_EN
      sgn_q <= sgn;
`endif
    end else if (step) begin
      acc_q <= acc_nxt;
      q_q   <= q_nxt;
    end
  end

endmodule

// File: rtl/seq_mult_core.sv
// Sequential shift-add multiplier: FSM, step counter and product register around seq_mult_dp.
// Define SEQ_MULT_SIGNED_EN to add per-operation two's-complement mode (sgn).
module seq_mult_core
  import seq_mult_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic      clk,
  input  logic      rst,
  seq_mult_if.slave bus
);
  localparam int unsigned     CW        = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST_STEP = CW'(WIDTH - 1);

  if (WIDTH < 2 || WIDTH > SEQ_MULT_MAX_WIDTH) begin : g_bad_width
    $error("seq_mult_core: WIDTH out of range");
  end

  seq_mult_state_t    state_q;
  seq_mult_state_t    state_nxt;
  logic [CW-1:0]      cnt_q;
  logic               accept;
  logic               step;
  logic               last;
  logic               busy_q;
  logic               done_q;
  logic [2*WIDTH-1:0] product_q;
  logic [2*WIDTH-1:0] dp_result;

  assign last        = (cnt_q == LAST_STEP);
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;

  always_comb begin
    state_nxt = state_q;
    accept    = 1'b0;
    step      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_nxt = CALC;
          accept    = 1'b1;
        end
      end
      CALC: begin
        step = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        if (bus.start) begin
          state_nxt = CALC;
          accept    = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (bus.clr) begin
      state_nxt = IDLE;
      accept    = 1'b0;
      step      = 1'b0;
    end
  end

  // busy/done come from the next state so both outputs are flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      state_q <= state_nxt;
      busy_q  <= (state_nxt == CALC);
      done_q  <= (state_nxt == DONE);
      if (bus.clr) begin
        cnt_q     <= '0;
        product_q <= '0;
      end else begin
        if (accept)    cnt_q <= '0;
        else if (step) cnt_q <= cnt_q + 1'b1;
        if (step && last) product_q <= dp_result;
      end
    end
  end

  seq_mult_dp #(.WIDTH(WIDTH)) u_dp (
    .clk          (clk),
    .rst          (rst),
    .clr          (bus.clr),
    .load         (accept),
    .step         (step),
`ifdef SEQ_MULT_SIGNED_EN
    .last         (last),
    .sgn          (bus.sgn),
`endif
    .multiplicand (bus.multiplicand),
    .multiplier   (bus.multiplier),
    .result       (dp_result)
  );

endmodule

// File: tb/tb_seq_mult_core.sv
// Self-checking bench for seq_mult_core: WIDTH=8 against a cycle model, WIDTH=16 directed.
`timescale 1ns/1ps
module tb_seq_mult_core;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sg  = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  seq_mult_if #(.WIDTH(8))  bus8 ();
  seq_mult_if #(.WIDTH(16)) bus16 ();
`ifdef SEQ_MULT_SIGNED_EN
  assign bus8.sgn  = sg;
  assign bus16.sgn = 1'b0;
`endif

  seq_mult_core #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));
  seq_mult_core #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b, input logic s);
    int sa, sb, p;
    sa = s ? int'($signed(a)) : int'(a);
    sb = s ? int'($signed(b)) : int'(b);
    p  = sa * sb;
    return p[15:0];
  endfunction

  // Behavioural model for the 8-bit core: result arrives WIDTH+1 cycles after acceptance.
  int unsigned m_left;
  logic        m_done;
  logic [15:0] m_prod, m_pend;
  logic        m_sgn;

`ifdef SEQ_MULT_SIGNED_EN
  assign m_sgn = sg;
`else
  assign m_sgn = 1'b0;
`endif

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_left <= 0; m_done <= 1'b0; m_prod <= '0; m_pend <= '0;
    end else if (bus8.clr) begin
      m_left <= 0; m_done <= 1'b0; m_prod <= '0;
    end else if (m_left == 0 && bus8.start) begin
      m_pend <= ref_mul(bus8.multiplicand, bus8.multiplier, m_sgn);
      m_left <= 8;
      m_done <= 1'b0;
    end else if (m_left != 0) begin
      m_left <= m_left - 1;
      m_done <= (m_left == 1);
      if (m_left == 1) m_prod <= m_pend;
    end else begin
      m_done <= 1'b0;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rst) begin
      check("model_busy",    32'(bus8.busy),    32'(m_left != 0));
      check("model_done",    32'(bus8.done),    32'(m_done));
      check("model_product", 32'(bus8.product), 32'(m_prod));
      check("busy_done_excl", 32'(bus8.busy & bus8.done), 32'd0);
    end
  end

  task automatic wait_done8(input int from, output int cyc);
    cyc = from;
    while (!bus8.done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                     input logic [15:0] exp, input bit b2b, input string name);
    int cyc;
    if (!b2b) @(negedge clk);
    bus8.multiplicand = a;
    bus8.multiplier   = b;
    sg                = s;
    bus8.start        = 1'b1;
    @(negedge clk);
    bus8.start        = 1'b0;
    bus8.multiplicand = ~a;
    bus8.multiplier   = b ^ 8'h5A;
    sg                = ~s;
    wait_done8(1, cyc);
    check({name, "_done_cycle"}, 32'(cyc), 32'd9);
    check({name, "_product"}, 32'(bus8.product), 32'(exp));
  endtask

  task automatic count_dones8(input int n, input string name);
    int seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus8.done) seen++;
    end
    check(name, 32'(seen), 32'd0);
  endtask

  initial begin
    int cyc;
    bus8.clr = 1'b0;  bus8.start = 1'b0;  bus8.multiplicand = '0;  bus8.multiplier = '0;
    bus16.clr = 1'b0; bus16.start = 1'b0; bus16.multiplicand = '0; bus16.multiplier = '0;
    #12;
    check("reset_busy",    32'(bus8.busy),    32'd0);
    check("reset_done",    32'(bus8.done),    32'd0);
    check("reset_product", 32'(bus8.product), 32'd0);
    check("reset_product16", bus16.product,   32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Latency shape of the first operation
    @(negedge clk);
    bus8.multiplicand = 8'd200; bus8.multiplier = 8'd150; bus8.start = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      bus8.start = 1'b0;
      check($sformatf("lat_busy_c%0d", c), 32'(bus8.busy), 32'(c <= 8));
      check($sformatf("lat_done_c%0d", c), 32'(bus8.done), 32'(c == 9));
    end
    check("lat_product", 32'(bus8.product), 32'h7530);

    op8(8'hFF, 8'hFF, 1'b0, 16'hFE01, 1'b0, "ff_ff");
    op8(8'h00, 8'h37, 1'b0, 16'h0000, 1'b1, "b2b_zero");
    op8(8'h0F, 8'h0F, 1'b0, 16'h00E1, 1'b0, "f_f");
    op8(8'hFD, 8'h05, 1'b0, 16'h04F1, 1'b0, "unsigned_fd_5");
`ifdef SEQ_MULT_SIGNED_EN
    op8(8'hFD, 8'h05, 1'b1, 16'hFFF1, 1'b0, "s_m3_5");
    op8(8'h80, 8'h80, 1'b1, 16'h4000, 1'b0, "s_m128_m128");
    op8(8'h7F, 8'hFF, 1'b1, 16'hFF81, 1'b1, "s_127_m1");
`endif

    // Start during CALC ignored; operands changed mid-operation
    @(negedge clk);
    bus8.multiplicand = 8'd200; bus8.multiplier = 8'd150; sg = 1'b0; bus8.start = 1'b1;
    @(negedge clk); bus8.start = 1'b0;
    @(negedge clk); bus8.multiplicand = 8'd3; bus8.multiplier = 8'd7;
    @(negedge clk);
    @(negedge clk); bus8.start = 1'b1;
    @(negedge clk); bus8.start = 1'b0;
    wait_done8(5, cyc);
    check("ignore_start_cycle",   32'(cyc), 32'd9);
    check("ignore_start_product", 32'(bus8.product), 32'h7530);
    count_dones8(12, "ignore_start_no_second_done");

    // Clear in cycle 5 of CALC
    @(negedge clk);
    bus8.multiplicand = 8'h12; bus8.multiplier = 8'h34; bus8.start = 1'b1;
    @(negedge clk); bus8.start = 1'b0;
    repeat (4) @(negedge clk);
    bus8.clr = 1'b1;
    @(negedge clk); bus8.clr = 1'b0;
    check("clr_busy",    32'(bus8.busy),    32'd0);
    check("clr_done",    32'(bus8.done),    32'd0);
    check("clr_product", 32'(bus8.product), 32'd0);
    count_dones8(12, "clr_no_done");

    // Clear and start together
    @(negedge clk);
    bus8.multiplicand = 8'h21; bus8.multiplier = 8'h43; bus8.clr = 1'b1; bus8.start = 1'b1;
    @(negedge clk); bus8.clr = 1'b0; bus8.start = 1'b0;
    check("clr_start_busy", 32'(bus8.busy), 32'd0);
    count_dones8(12, "clr_start_no_done");

    // WIDTH=16 full-scale product
    @(negedge clk);
    bus16.multiplicand = 16'hFFFF; bus16.multiplier = 16'hFFFF; bus16.start = 1'b1;
    @(negedge clk); bus16.start = 1'b0; bus16.multiplicand = 16'h1234;
    cyc = 1;
    while (!bus16.done && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    check("w16_done_cycle", 32'(cyc), 32'd17);
    check("w16_product",    bus16.product, 32'hFFFE_0001);

    // Asynchronous reset mid-CALC
    op8(8'h0F, 8'h0F, 1'b0, 16'h00E1, 1'b0, "pre_rst");
    @(negedge clk);
    bus8.multiplicand = 8'hAB; bus8.multiplier = 8'hCD; bus8.start = 1'b1;
    @(negedge clk); bus8.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_busy", 32'(bus8.busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("rst_busy",      32'(bus8.busy),    32'd0);
    check("rst_done",      32'(bus8.done),    32'd0);
    check("rst_product",   32'(bus8.product), 32'd0);
    check("rst_product16", bus16.product,     32'd0);
    @(negedge clk);
    rst = 1'b1;
    count_dones8(12, "rst_no_done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_mult_core.md
# seq_mult_core

Parametrised sequential shift-add multiplier core for the multiplication system, replacing the fixed 8-bit serial SPM/shift-register path. It multiplies two WIDTH-bit operands into a 2·WIDTH-bit product, one partial product per clock, with a start/busy/done handshake. It sits between the control unit, which issues `start` from the debounced centre button, and the product display. Signed operation is optional at build time.

## Interface
- `WIDTH`, default 8: operand width; legal range 2..32; product is 2·WIDTH bits.
- `clk`  in  1  system clock (the divided clock in the top level); all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `clr`  in  1  synchronous clear; aborts any operation.
- `start`  in  1  request; sampled only in IDLE or DONE.
- `multiplicand`  in  WIDTH  operand A; captured on the accepting edge only.
- `multiplier`  in  WIDTH  operand B; captured on the accepting edge only.
- `sgn`  in  1  two's-complement mode select; captured with the operands. Present only with `SEQ_MULT_SIGNED_EN`.
- `busy`  out  1  high while in CALC.
- `done`  out  1  single-cycle pulse; product is final.
- `product`  out  2·WIDTH  result register; holds until the next accepted start or clear.

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE → CALC when `start` = 1. On that edge:
  - latch `multiplicand` into M and `multiplier` into Q;
  - accumulator ACC (WIDTH+1 bits) ← 0;
  - step counter ← 0.
- Each CALC step:
  - if Q[0] = 1, ACC ← ACC + M;
  - shift {ACC, Q} right by one;
  - increment the counter.
- Unsigned step:
  - M is zero-extended to WIDTH+1 bits;
  - the shift is logical; the carry sits in ACC[WIDTH].
- Signed step (`sgn` = 1):
  - M is sign-extended;
  - the shift is arithmetic;
  - on the final step (counter = WIDTH−1), if Q[0] = 1, ACC ← ACC − M instead of adding.
- CALC → DONE on the edge that performs step WIDTH−1. On that edge `product` ← the final {ACC[WIDTH−1:0], Q}.
- DONE lasts one cycle, then returns to IDLE. If `start` = 1 while in DONE, the start is accepted directly (back-to-back, DONE → CALC).
- `start` during CALC is ignored. It is not queued.
- `clr` = 1 on any edge:
  - state ← IDLE; `product` ← 0; `done` ← 0; `busy` ← 0;
  - `clr` has priority over `start` in the same cycle.
- Operand inputs may change freely after the accepting edge with no effect on the result.

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `product` 0, ACC/Q/M/counter 0.
- Reset is asserted asynchronously and takes effect immediately, including mid-CALC.
- Latency: `start` high in cycle 0 → `busy` high in cycles 1..WIDTH → `done` high in cycle WIDTH+1 only.
- Throughput: one result every WIDTH+1 cycles with back-to-back starts.
- `product` changes only on the CALC→DONE edge or on clear/reset. It is never an intermediate value.
- `busy` and `done` are mutually exclusive. Both outputs are registered.

## Configuration
- `SEQ_MULT_SIGNED_EN` defined:
  - the `sgn` port exists;
  - signed or unsigned mode is selected per operation.
- `SEQ_MULT_SIGNED_EN` undefined:
  - the `sgn` port is absent;
  - the core is unsigned-only and the final-step subtract logic is not built.

## Structure
- Shared package `seq_mult_pkg`:
  - state typedef, encoded IDLE = 2'b00, CALC = 2'b01, DONE = 2'b10;
  - `SEQ_MULT_MAX_WIDTH` = 32.
- Counter width `$clog2(WIDTH)` is computed locally in the module.
- One sub-module, `seq_mult_dp`, holds M, ACC, Q and the add/subtract/shift step. The FSM and counter stay in `seq_mult_core`.

## Test plan
- WIDTH=8, unsigned: 200 × 150 → `product` = 0x7530; `done` in cycle 9; `busy` in cycles 1–8.
- WIDTH=8, unsigned: 0xFF × 0xFF → 0xFE01. Then a back-to-back start in DONE with 0 × 0x37 → 0x0000 nine cycles later.
- WIDTH=8, `SEQ_MULT_SIGNED_EN`, `sgn` = 1:
  - −3 × 5 → 0xFFF1;
  - −128 × −128 → 0x4000;
  - 127 × −1 → 0xFF81.
- WIDTH=16, unsigned: 0xFFFF × 0xFFFF → 0xFFFE0001; `done` in cycle 17.
- `start` pulsed again in cycle 4 of a CALC: ignored, and the first result is unchanged. Operand inputs changed in cycle 2: no effect.
- Boundary resets:
  - `clr` in cycle 5 of CALC → IDLE next cycle, `product` = 0, no `done`;
  - `clr` and `start` together → stays IDLE;
  - `rst` low mid-CALC → all outputs 0 immediately.
